// File: rtl/i2c_target_responder_pkg.sv
// Shared I2C definitions: FSM state encoding, default target address and
// synchronizer depth. Used by the target responder and the address translator.
package i2c_target_responder_pkg;

    localparam logic [6:0]  DEFAULT_TARGET_ADDR = 7'h48;
    localparam int unsigned SYNC_DEPTH          = 2;
    localparam int unsigned BYTE_BITS           = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_e;

endpackage

// File: rtl/i2c_target_responder_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and flags bus events.
// Ports:
//   clk, rst            system clock, async active-high reset
//   scl_i, sda_i        raw bus lines (asynchronous to clk)
//   sda_o               synchronized SDA level
//   scl_rise_o/fall_o   one-clk pulse on a synchronized SCL edge
//   start_o / stop_o    one-clk pulse on START (incl. repeated) / STOP
module i2c_bus_sync
    import i2c_target_responder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_DEPTH-1:0] scl_sync_q;
    logic [SYNC_DEPTH-1:0] sda_sync_q;
    logic                  scl_prev_q;
    logic                  sda_prev_q;
    logic                  scl_s;
    logic                  sda_s;

    // Synchronizer chains plus one edge-detect stage; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_DEPTH-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_DEPTH-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_DEPTH-1];
    assign sda_s = sda_sync_q[SYNC_DEPTH-1];

    // SDA may only move while SCL is high to signal START/STOP.
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target exposing NUM_REGS 8-bit registers behind an auto-incrementing
// pointer. Write: [addr+W][ptr][data...]. Read: [addr+R][data...] from pointer.
// Ports:
//   clk, rst        system clock (>= 8x SCL), async active-high reset
//   scl_i, sda_i    bus lines (sda_i is the wired-AND bus level)
//   sda_oe          1 pulls SDA low
//   regs_o          flat register file, register k at [8k+7:8k]
//   wr_strobe       one-clk pulse per register written
//   busy            high from address match until STOP or release
module i2c_target_responder
    import i2c_target_responder_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int unsigned NUM_REGS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_strobe,
    output logic                  busy
);

    localparam int unsigned PW = $clog2(NUM_REGS);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync u_bus_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_state_e            state_q;
    logic [3:0]            bit_cnt_q;
    logic [7:0]            shift_q;
    logic [PW-1:0]         ptr_q;
    logic [8*NUM_REGS-1:0] regs_q;
    logic                  sda_oe_q;
    logic                  busy_q;
    logic                  wr_strobe_q;

    logic                  byte_done;
    logic                  addr_match;
    logic [PW-1:0]         ptr_inc;
    logic [7:0]            rd_byte;
    logic [7:0]            rd_next;

    assign byte_done  = (bit_cnt_q == 4'(BYTE_BITS));
    // General call (7'h00) never matches.
    assign addr_match = (shift_q[7:1] == TARGET_ADDR) && (shift_q[7:1] != 7'h00);
    assign ptr_inc    = ptr_q + PW'(1);
    assign rd_byte    = regs_q[{ptr_q, 3'b000} +: 8];
    assign rd_next    = regs_q[{ptr_inc, 3'b000} +: 8];

    // Protocol FSM; SDA drive only changes on SCL falling edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            regs_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (stop_det) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else if (start_det) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            bit_cnt_q <= '0;
                            if (addr_match) begin
                                state_q  <= ST_ADDR_ACK;
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                            end else begin
                                state_q  <= ST_WAIT_STOP;
                                sda_oe_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // shift_q[0] still holds the R/W bit.
                        if (scl_fall) begin
                            if (shift_q[0]) begin
                                state_q  <= ST_RDATA;
                                sda_oe_q <= ~rd_byte[7];
                                shift_q  <= {rd_byte[6:0], 1'b0};
                            end else begin
                                state_q  <= ST_PTR;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            bit_cnt_q <= '0;
                            sda_oe_q  <= 1'b1;
                            if (state_q == ST_PTR) begin
                                ptr_q   <= shift_q[PW-1:0];
                                state_q <= ST_PTR_ACK;
                            end else begin
                                regs_q[{ptr_q, 3'b000} +: 8] <= shift_q;
                                wr_strobe_q <= 1'b1;
                                ptr_q       <= ptr_inc;
                                state_q     <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            state_q  <= ST_WDATA;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                bit_cnt_q <= '0;
                                sda_oe_q  <= 1'b0;
                                state_q   <= ST_RDATA_ACK;
                            end else begin
                                sda_oe_q <= ~shift_q[7];
                                shift_q  <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        // Capture master ACK/NACK into shift_q[0].
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s};
                        end else if (scl_fall) begin
                            if (!shift_q[0]) begin
                                ptr_q     <= ptr_inc;
                                state_q   <= ST_RDATA;
                                bit_cnt_q <= '0;
                                sda_oe_q  <= ~rd_next[7];
                                shift_q   <= {rd_next[6:0], 1'b0};
                            end else begin
                                state_q  <= ST_WAIT_STOP;
                                sda_oe_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs_o    = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench: bit-banged I2C master against i2c_target_responder with a scoreboard
// of expected ACKs, read bytes and register-file contents.
module tb_i2c_target_responder;

    localparam int unsigned T = 10;   // clk cycles per SCL quarter period

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        sda_bus;
    logic        sda_oe;
    logic        wr_strobe;
    logic        busy;
    logic [31:0] regs_o;

    // Open-drain bus: wired-AND of master and target.
    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_responder #(
        .TARGET_ADDR (7'h48),
        .NUM_REGS    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   strobe_cnt     = 0;
    int   oe_viol_cnt    = 0;
    int   drive_viol_cnt = 0;
    logic oe_prev        = 1'b0;
    logic watch_quiet    = 1'b0;

    // Bus-side monitors: strobe count, SDA drive changes while SCL high,
    // and any drive while the target must stay silent.
    always @(negedge clk) begin
        oe_prev <= sda_oe;
        if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (!rst && scl_m && (sda_oe !== oe_prev)) oe_viol_cnt <= oe_viol_cnt + 1;
        if (watch_quiet && sda_oe === 1'b1) drive_viol_cnt <= drive_viol_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_m = b;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        seen = sda_bus;
        wait_clk(T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    // Also serves as repeated START when SCL is low.
    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b0;
        wait_clk(T);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clk(T);
        scl_m = 1'b1;
        wait_clk(T);
        sda_m = 1'b1;
        wait_clk(T);
    endtask

    task automatic wr_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic s;
        sb_push(tag, {31'd0, exp_ack});
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        sb_pop({31'd0, ~s});
    endtask

    task automatic rd_byte(input string tag, input logic m_ack, input logic [7:0] exp);
        logic       s;
        logic [7:0] d;
        sb_push(tag, {24'd0, exp});
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(~m_ack, s);
        sb_pop({24'd0, d});
    endtask

    task automatic regs_chk(input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop(regs_o);
    endtask

    int s0;
    int d0;

    initial begin
        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check_eq("rst_regs", regs_o, 32'h0);
        rst = 1'b0;
        wait_clk(4);

        // Single write with STOP
        s0 = strobe_cnt;
        bus_start();
        wr_byte("t1_addr_ack", 8'h90, 1'b1);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        wr_byte("t1_ptr_ack", 8'h01, 1'b1);
        wr_byte("t1_data_ack", 8'hA5, 1'b1);
        bus_stop();
        wait_clk(4);
        regs_chk("t1_regs", 32'h0000_A500);
        check_eq("t1_strobes", 32'(strobe_cnt - s0), 32'd1);
        check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

        // Write burst wrapping the pointer 3 -> 0
        s0 = strobe_cnt;
        bus_start();
        wr_byte("t2_addr_ack", 8'h90, 1'b1);
        wr_byte("t2_ptr_ack", 8'h03, 1'b1);
        wr_byte("t2_d0_ack", 8'h11, 1'b1);
        wr_byte("t2_d1_ack", 8'h22, 1'b1);
        bus_stop();
        wait_clk(4);
        regs_chk("t2_regs", 32'h1100_A522);
        check_eq("t2_strobes", 32'(strobe_cnt - s0), 32'd2);

        bus_start();
        wr_byte("t3_addr_ack", 8'h90, 1'b1);
        wr_byte("t3_ptr_ack", 8'h02, 1'b1);
        wr_byte("t3_data_ack", 8'h5C, 1'b1);
        bus_stop();
        wait_clk(4);
        regs_chk("t3_regs", 32'h115C_A522);

        // Pointer set, repeated START, read ACK then NACK
        bus_start();
        wr_byte("t4_addr_ack", 8'h90, 1'b1);
        wr_byte("t4_ptr_ack", 8'h02, 1'b1);
        bus_start();
        wr_byte("t4_raddr_ack", 8'h91, 1'b1);
        rd_byte("t4_rd_reg2", 1'b1, 8'h5C);
        rd_byte("t4_rd_reg3", 1'b0, 8'h11);
        wait_clk(4);
        check_eq("t4_released", {31'd0, sda_oe}, 32'd0);
        check_eq("t4_busy_nack", {31'd0, busy}, 32'd0);
        bus_stop();
        wait_clk(4);

        // Read burst wrapping the pointer 3 -> 0 -> 1
        bus_start();
        wr_byte("t5_addr_ack", 8'h90, 1'b1);
        wr_byte("t5_ptr_ack", 8'h03, 1'b1);
        bus_start();
        wr_byte("t5_raddr_ack", 8'h91, 1'b1);
        rd_byte("t5_rd_reg3", 1'b1, 8'h11);
        rd_byte("t5_rd_reg0", 1'b1, 8'h22);
        rd_byte("t5_rd_reg1", 1'b0, 8'hA5);
        bus_stop();
        wait_clk(4);
        regs_chk("t5_regs", 32'h115C_A522);

        // Foreign address and general call: target stays silent
        d0 = drive_viol_cnt;
        s0 = strobe_cnt;
        watch_quiet = 1'b1;
        bus_start();
        wr_byte("t6_addr_nack", 8'h44, 1'b0);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        wr_byte("t6_byte_nack", 8'h02, 1'b0);
        bus_stop();
        bus_start();
        wr_byte("t6_gcall_nack", 8'h00, 1'b0);
        wr_byte("t6_gbyte_nack", 8'h01, 1'b0);
        bus_stop();
        wait_clk(4);
        watch_quiet = 1'b0;
        check_eq("t6_quiet", 32'(drive_viol_cnt - d0), 32'd0);
        check_eq("t6_strobes", 32'(strobe_cnt - s0), 32'd0);
        regs_chk("t6_regs", 32'h115C_A522);

        // STOP after a partial data byte: no write
        s0 = strobe_cnt;
        bus_start();
        wr_byte("t7_addr_ack", 8'h90, 1'b1);
        wr_byte("t7_ptr_ack", 8'h00, 1'b1);
        begin
            logic s;
            clock_bit(1'b1, s);
            clock_bit(1'b0, s);
            clock_bit(1'b1, s);
            clock_bit(1'b0, s);
        end
        bus_stop();
        wait_clk(4);
        regs_chk("t7_regs", 32'h115C_A522);
        check_eq("t7_strobes", 32'(strobe_cnt - s0), 32'd0);
        check_eq("t7_busy", {31'd0, busy}, 32'd0);

        // Reset while target drives read data (reg0 = 0x22, MSB 0 -> drive low)
        bus_start();
        wr_byte("t8_raddr_ack", 8'h91, 1'b1);
        wait_clk(5);
        check_eq("t8_driving", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t8_rst_release", {31'd0, sda_oe}, 32'd0);
        check_eq("t8_rst_regs", regs_o, 32'h0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        d0 = drive_viol_cnt;
        watch_quiet = 1'b1;
        begin
            logic s;
            for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        end
        bus_stop();
        wait_clk(4);
        watch_quiet = 1'b0;
        check_eq("t8_quiet_after_rst", 32'(drive_viol_cnt - d0), 32'd0);

        s0 = strobe_cnt;
        bus_start();
        wr_byte("t8_addr_ack", 8'h90, 1'b1);
        wr_byte("t8_ptr_ack", 8'h01, 1'b1);
        wr_byte("t8_data_ack", 8'h3C, 1'b1);
        bus_stop();
        wait_clk(4);
        regs_chk("t8_regs", 32'h0000_3C00);
        check_eq("t8_strobes", 32'(strobe_cnt - s0), 32'd1);

        check_eq("oe_change_scl_high", 32'(oe_viol_cnt), 32'd0);
        check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
